// File: rtl/game_timer.sv
// game_timer: MM:SS elapsed-time counter, started by the gameStart level and frozen by WinSig.
// Define BEST_TIME_EN to build the best-win-time register; otherwise best_time/new_best are tied to 0.
module game_timer #(
   parameter int TICK_DIV = 50000000,
   parameter int MAX_MIN  = 99
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        gameStart,
   input  logic        WinSig,
   input  logic        pause,
   output logic [3:0]  min_tens,
   output logic [3:0]  min_ones,
   output logic [3:0]  sec_tens,
   output logic [3:0]  sec_ones,
   output logic        running,
   output logic        overflow,
   output logic [15:0] best_time,
   output logic        new_best
);

   localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [3:0]       MAX_TENS = 4'(MAX_MIN / 10);
   localparam logic [3:0]       MAX_ONES = 4'(MAX_MIN % 10);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUNNING = 2'b01,
      STOPPED = 2'b10
   } timerState_t;

   timerState_t      stateReg, stateNext;

   logic             startMeta, startSync, startDly;
   logic             winMeta, winSync;
   logic [1:0]       syncFill;
   logic             edgeValid, startRise, startFall;

   logic [PRE_W-1:0] preCnt, preNext;
   logic [3:0]       secOnes, secOnesNext;
   logic [3:0]       secTens, secTensNext;
   logic [3:0]       minOnes, minOnesNext;
   logic [3:0]       minTens, minTensNext;
   logic             overflowReg, overflowNext;
   logic             runningReg;
   logic             atMax;

   // Two-flop synchronisers plus a delay flop on gameStart for edge detection.
   always_ff @(posedge CLK) begin
      if (RST) begin
         startMeta <= 1'b0;
         startSync <= 1'b0;
         startDly  <= 1'b0;
         winMeta   <= 1'b0;
         winSync   <= 1'b0;
         syncFill  <= 2'd0;
      end else begin
         startMeta <= gameStart;
         startSync <= startMeta;
         startDly  <= startSync;
         winMeta   <= WinSig;
         winSync   <= winMeta;
         if (syncFill != 2'd3)
            syncFill <= syncFill + 2'd1;
      end
   end

   // Edges only count once the chain has refilled after reset, so a level held
   // high through RST is not mistaken for a fresh rise.
   assign edgeValid = (syncFill == 2'd3);
   assign startRise = edgeValid &&  startSync && !startDly;
   assign startFall = edgeValid && !startSync &&  startDly;

   assign atMax = (minTens == MAX_TENS) && (minOnes == MAX_ONES) &&
                  (secTens == 4'd5) && (secOnes == 4'd9);

   always_comb begin
      stateNext    = stateReg;
      preNext      = preCnt;
      secOnesNext  = secOnes;
      secTensNext  = secTens;
      minOnesNext  = minOnes;
      minTensNext  = minTens;
      overflowNext = overflowReg;

      case (stateReg)
         IDLE, STOPPED: begin
            if (!winSync && startRise) begin
               stateNext    = RUNNING;
               preNext      = '0;
               secOnesNext  = 4'd0;
               secTensNext  = 4'd0;
               minOnesNext  = 4'd0;
               minTensNext  = 4'd0;
               overflowNext = 1'b0;
            end
         end

         RUNNING: begin
            if (winSync || startFall) begin
               stateNext = STOPPED;
            end else if (!pause) begin
               if (preCnt == PRE_LAST) begin
                  preNext = '0;
                  if (atMax) begin
                     overflowNext = 1'b1;
                  end else if (secOnes == 4'd9) begin
                     // Ripple the carry through every digit within this one cycle.
                     secOnesNext = 4'd0;
                     if (secTens == 4'd5) begin
                        secTensNext = 4'd0;
                        if (minOnes == 4'd9) begin
                           minOnesNext = 4'd0;
                           minTensNext = minTens + 4'd1;
                        end else begin
                           minOnesNext = minOnes + 4'd1;
                        end
                     end else begin
                        secTensNext = secTens + 4'd1;
                     end
                  end else begin
                     secOnesNext = secOnes + 4'd1;
                  end
               end else begin
                  preNext = preCnt + 1'b1;
               end
            end
         end

         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stateReg    <= IDLE;
         preCnt      <= '0;
         secOnes     <= 4'd0;
         secTens     <= 4'd0;
         minOnes     <= 4'd0;
         minTens     <= 4'd0;
         overflowReg <= 1'b0;
         runningReg  <= 1'b0;
      end else begin
         stateReg    <= stateNext;
         preCnt      <= preNext;
         secOnes     <= secOnesNext;
         secTens     <= secTensNext;
         minOnes     <= minOnesNext;
         minTens     <= minTensNext;
         overflowReg <= overflowNext;
         runningReg  <= (stateNext == RUNNING);
      end
   end

   assign min_tens = minTens;
   assign min_ones = minOnes;
   assign sec_tens = secTens;
   assign sec_ones = secOnes;
   assign running  = runningReg;
   assign overflow = overflowReg;

`ifdef BEST_TIME_EN
   logic [15:0] bestReg;
   logic [15:0] curTime;
   logic        newBestReg;
   logic        winStop;

   // BCD digits compare correctly as a plain unsigned 16-bit value.
   assign curTime = {minTens, minOnes, secTens, secOnes};
   assign winStop = (stateReg == RUNNING) && winSync;

   always_ff @(posedge CLK) begin
      if (RST) begin
         bestReg    <= 16'h9959;
         newBestReg <= 1'b0;
      end else begin
         newBestReg <= 1'b0;
         if (winStop && !overflowReg && (curTime < bestReg)) begin
            bestReg    <= curTime;
            newBestReg <= 1'b1;
         end
      end
   end

   assign best_time = bestReg;
   assign new_best  = newBestReg;
`else
   assign best_time = 16'h0000;
   assign new_best  = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer (TICK_DIV=4): expected words are queued at stimulus time
// and popped against the DUT outputs, sampled 1 ns after each rising edge.
module tb_game_timer;

   logic        CLK;
   logic        RST;
   logic        gameStart;
   logic        WinSig;
   logic        pause;
   logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
   logic        running, overflow;
   logic [15:0] best_time;
   logic        new_best;

   int vecCount  = 0;
   int missCount = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sbEntry_t;

   sbEntry_t sbQ[$];

   game_timer #(.TICK_DIV(4), .MAX_MIN(99)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .gameStart (gameStart),
      .WinSig    (WinSig),
      .pause     (pause),
      .min_tens  (min_tens),
      .min_ones  (min_ones),
      .sec_tens  (sec_tens),
      .sec_ones  (sec_ones),
      .running   (running),
      .overflow  (overflow),
      .best_time (best_time),
      .new_best  (new_best)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("FAIL %s: got %h expected %h", tag, observed, expected);
      end else begin
         $display("ok   %s: %h", tag, observed);
      end
   endtask

   // Expected status word {overflow, running, MM:SS in BCD} built from a plain seconds count.
   function automatic logic [31:0] timeWord(input logic ov, input logic run, input int secs);
      int mm, ss;
      mm = secs / 60;
      ss = secs % 60;
      return {14'd0, ov, run, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic pushExp(input string tag, input logic [31:0] exp);
      sbEntry_t e;
      e.tag = tag;
      e.exp = exp;
      sbQ.push_back(e);
   endtask

   task automatic popCheck(input logic [31:0] observed);
      sbEntry_t e;
      if (sbQ.size() == 0) begin
         checkVal("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
         e = sbQ.pop_front();
         checkVal(e.tag, observed, e.exp);
      end
   endtask

   function automatic logic [31:0] obsWord();
      return {14'd0, overflow, running, min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic expectTime(input string tag, input logic ov, input logic run, input int secs);
      pushExp(tag, timeWord(ov, run, secs));
      popCheck(obsWord());
   endtask

   task automatic expectBest(input string tag, input logic [15:0] bestExp, input logic pulseExp);
      logic [15:0] bt;
      logic        np;
`ifdef BEST_TIME_EN
      bt = bestExp;
      np = pulseExp;
`else
      bt = 16'h0000;
      np = 1'b0;
`endif
      pushExp(tag, {15'd0, np, bt});
      popCheck({15'd0, new_best, best_time});
   endtask

   // Leaves the bench 1 ns after the edge on which RUNNING is entered (prescaler 0).
   task automatic startGame(input int prevSecs, input logic prevOv);
      gameStart = 1'b0;
      WinSig    = 1'b0;
      cyc(5);
      gameStart = 1'b1;
      pushExp("start_edge2_idle", timeWord(prevOv, 1'b0, prevSecs));
      pushExp("start_edge3_run", timeWord(1'b0, 1'b1, 0));
      cyc(2);
      popCheck(obsWord());
      cyc(1);
      popCheck(obsWord());
   endtask

   // Raise WinSig 'late' cycles after the tick for 'secs'; the stop lands 3 edges later.
   task automatic winStop(input int secs, input int late, input logic [15:0] bestExp, input logic pulseExp);
      cyc(4 * secs + late);
      WinSig = 1'b1;
      cyc(3);
      expectTime("win_frozen", 1'b0, 1'b0, secs);
      expectBest("win_best", bestExp, pulseExp);
      cyc(1);
      expectBest("win_best_next", bestExp, 1'b0);
   endtask

   initial begin
      RST       = 1'b1;
      gameStart = 1'b0;
      WinSig    = 1'b0;
      pause     = 1'b0;

      cyc(1);
      expectTime("reset_state", 1'b0, 1'b0, 0);
      expectBest("reset_best", 16'h9959, 1'b0);
      cyc(1);
      RST = 1'b0;

      // Game 1: count, pause at 00:05, win at 00:23.
      startGame(0, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         cyc(3);
         expectTime("count_before", 1'b0, 1'b1, k - 1);
         cyc(1);
         expectTime("count_tick", 1'b0, 1'b1, k);
      end
      cyc(2);
      pause = 1'b1;
      cyc(10);
      expectTime("pause_hold", 1'b0, 1'b1, 5);
      pause = 1'b0;
      cyc(1);
      expectTime("pause_resume_pre", 1'b0, 1'b1, 5);
      cyc(1);
      expectTime("pause_resume_tick", 1'b0, 1'b1, 6);
      for (int k = 7; k <= 10; k++) begin
         cyc(3);
         expectTime("count_before", 1'b0, 1'b1, k - 1);
         cyc(1);
         expectTime("count_tick", 1'b0, 1'b1, k);
      end
      cyc(4 * 13);
      expectTime("at_23", 1'b0, 1'b1, 23);
      WinSig = 1'b1;
      cyc(2);
      expectTime("win_latency_2", 1'b0, 1'b1, 23);
      cyc(1);
      expectTime("win_latency_3", 1'b0, 1'b0, 23);
      expectBest("win23_best", 16'h0023, 1'b1);
      cyc(1);
      expectBest("win23_best_next", 16'h0023, 1'b0);
      cyc(10);
      expectTime("stopped_hold", 1'b0, 1'b0, 23);

      // Reset mid-count at 00:17 with gameStart left high.
      startGame(23, 1'b0);
      cyc(4 * 17);
      expectTime("at_17", 1'b0, 1'b1, 17);
      RST = 1'b1;
      cyc(1);
      expectTime("reset_midrun", 1'b0, 1'b0, 0);
      expectBest("reset_midrun_best", 16'h9959, 1'b0);
      RST = 1'b0;
      cyc(10);
      expectTime("no_restart_level", 1'b0, 1'b0, 0);

      // Best-time sequence: 00:30 improves, 00:45 (stop on a tick edge) does not, 00:12 improves.
      startGame(0, 1'b0);
      winStop(30, 0, 16'h0030, 1'b1);
      startGame(30, 1'b0);
      winStop(45, 1, 16'h0030, 1'b0);
      startGame(45, 1'b0);
      winStop(12, 0, 16'h0012, 1'b1);

      // Stop by gameStart fall never touches best_time.
      startGame(12, 1'b0);
      cyc(4 * 3);
      gameStart = 1'b0;
      cyc(3);
      expectTime("fall_stop", 1'b0, 1'b0, 3);
      expectBest("fall_best", 16'h0012, 1'b0);

      // Carries and saturation.
      startGame(3, 1'b0);
      cyc(4 * 59);
      expectTime("at_0059", 1'b0, 1'b1, 59);
      cyc(3);
      expectTime("pre_0100", 1'b0, 1'b1, 59);
      cyc(1);
      expectTime("carry_0100", 1'b0, 1'b1, 60);
      cyc(4 * (599 - 60));
      expectTime("at_0959", 1'b0, 1'b1, 599);
      cyc(4);
      expectTime("carry_1000", 1'b0, 1'b1, 600);
      cyc(4 * (5999 - 600));
      expectTime("at_9959", 1'b0, 1'b1, 5999);
      cyc(4);
      expectTime("saturate", 1'b1, 1'b1, 5999);
      cyc(8);
      expectTime("saturate_hold", 1'b1, 1'b1, 5999);
      WinSig = 1'b1;
      cyc(3);
      expectTime("overflow_win", 1'b1, 1'b0, 5999);
      expectBest("overflow_best", 16'h0012, 1'b0);

      checkVal("scoreboard_drained", 32'(sbQ.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
